cp0_exc_unit: RTL and testbench
===============================

Name: cp0_exc_unit

Overview:
- Coprocessor-0 for the P7 five-stage MIPS pipeline; sits in the M stage.
- Consumes the exception codes that the Decode stage produces (RI=10, Syscall=8) and that later stages merge into the M-stage code, plus the branch-delay flag and the 6 hardware interrupt lines.
- Decides whether to take an exception or interrupt, records SR/Cause/EPC, and serves mfc0/mtc0/eret.
- Drives the request and return-address signals that the fetch stage and the pipeline flush use.

Parameters:
- HANDLER_PC, 32'h0000_4180, exception entry address presented on handler_pc.
- PRID_VAL, 32'h2004_0707, read-only PRId contents.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- a1  in  5  mfc0 read register number (rd field)
- a2  in  5  mtc0 write register number
- din  in  32  mtc0 write data (forwarded rt value)
- we  in  1  mtc0 write enable
- m_pc  in  32  PC of the M-stage instruction (or the bubble's PC)
- m_exc  in  5  accumulated exception code, 0 = none
- m_bd  in  1  M-stage instruction is in a delay slot
- hwint  in  6  external interrupt lines, level-sensitive
- eret  in  1  eret in M stage
- dout  out  32  mfc0 read data (combinational)
- req  out  1  take exception/interrupt this cycle (combinational)
- epc_out  out  32  current EPC register, eret target
- handler_pc  out  32  constant HANDLER_PC

Behaviour:
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC(14): 32 bits, bits[1:0] always 0.
  - PRId(15): PRID_VAL.
- Reset (async): SR=0, Cause=0, EPC=0. While reset is asserted: req=0, dout=0 and epc_out=0.
- int_req = !EXL & IE & |(hwint & IM), using current SR and the live hwint.
- exc_req = !EXL & (m_exc != 0).
- req = int_req | exc_req. Combinational, with the same-cycle effect on fetch.
- Every cycle, unconditionally: Cause.IP <= hwint.
- When req=1, on the next clock edge:
  - EXL <= 1.
  - ExcCode <= int_req ? 0 : m_exc. Interrupt has priority over a simultaneous exception.
  - BD <= m_bd.
  - EPC <= (m_bd ? m_pc-4 : m_pc) & ~32'h3.
- Else if eret=1: EXL <= 0. No other state changes.
- Else if we=1:
  - a2=12 writes IM, EXL and IE from din.
  - a2=14 writes EPC = din & ~3.
  - a2=13, a2=15 and all other addresses are ignored.
- When req=1, a same-cycle mtc0 and a same-cycle eret are both discarded. The flushed instruction must not commit.
- While EXL=1:
  - req stays 0 regardless of hwint or m_exc. No nesting.
  - Cause.IP keeps tracking hwint.
- dout:
  - a1 in {12,13,14,15} returns the register value as of before this cycle's edge.
  - Any other a1 returns 0.
  - No internal write-to-read bypass; the pipeline forwards.
- epc_out is the registered EPC. An mtc0 to EPC is visible on the cycle after the write.
- Reset mid-handler: EXL clears immediately and req is forced low.

Test Plan:
- Reset, then read each register:
  - a1=12/13/14 -> dout=0.
  - a1=15 -> dout=32'h2004_0707.
  - a1=7 -> dout=0.
- Syscall:
  - Stimulus: m_exc=8, m_pc=0x3010, m_bd=0.
  - Same cycle: req=1.
  - Next cycle: Cause[6:2]=8, EPC=0x3010, SR.EXL=1, req=0 even with m_exc still 8.
- RI in delay slot:
  - Stimulus: m_exc=10, m_pc=0x3024, m_bd=1.
  - Required: Cause=0x8000_0028, EPC=0x3020.
- Interrupt priority and masking:
  - Stimulus: mtc0 SR=0x0000_0401, then hwint=6'b000001 together with m_exc=10 at m_pc=0x3040.
  - Required: req=1, then ExcCode=0, EPC=0x3040, Cause.IP=1.
  - Repeat with SR=0x0000_0801 -> req=0.
- eret and mtc0 collisions:
  - Under EXL=1, eret -> EXL=0 next cycle. With a pending enabled hwint, req=1 the cycle after.
  - mtc0 EPC=0x3007 issued together with req=1 -> EPC not overwritten.
  - mtc0 EPC=0x3007 with no req -> epc_out=0x3004.
- Asynchronous reset:
  - Stimulus: assert reset between clock edges while EXL=1, EPC=0x3010.
  - Required: req, SR, EPC and epc_out read 0 before the next edge.

Source files
------------

// File: rtl/cp0_exc_unit_if.sv
// CP0 pipeline-side bundle: mfc0/mtc0 port, M-stage exception inputs,
// interrupt lines and the request/return-address outputs.
interface cp0_exc_unit_if;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] m_pc;
    logic [4:0]  m_exc;
    logic        m_bd;
    logic [5:0]  hwint;
    logic        eret;
    logic [31:0] dout;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;

    modport master (
        output a1, a2, din, we,
        output m_pc, m_exc, m_bd,
        output hwint, eret,
        input  dout, req,
        input  epc_out, handler_pc
    );

    modport slave (
        input  a1, a2, din, we,
        input  m_pc, m_exc, m_bd,
        input  hwint, eret,
        output dout, req,
        output epc_out, handler_pc
    );
endinterface

// File: rtl/cp0_exc_unit.sv
// Coprocessor 0 for the P7 pipeline: SR/Cause/EPC/PRId,
// exception and interrupt entry, eret, mfc0/mtc0.
module cp0_exc_unit #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL   = 32'h2004_0707
) (
    input logic        clk,
    input logic        reset,
    cp0_exc_unit_if.slave bus
);
    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [29:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [31:0] sr;
    logic [31:0] cause;
    logic [31:0] epc_full;
    logic [31:0] epc_sel;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign sr       = {16'b0, im, 8'b0, exl, ie};
    assign cause    = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
    assign epc_full = {epc, 2'b00};

    assign int_req = !exl && ie && |(bus.hwint & im);
    assign exc_req = !exl && (bus.m_exc != 5'd0);
    assign req     = !reset && (int_req || exc_req);

    // Delay-slot instructions restart at the branch
    assign epc_sel = bus.m_bd ? (bus.m_pc - 32'd4) : bus.m_pc;

    always_comb begin
        rd_data = 32'd0;
        unique case (bus.a1)
            5'd12:   rd_data = sr;
            5'd13:   rd_data = cause;
            5'd14:   rd_data = epc_full;
            5'd15:   rd_data = PRID_VAL;
            default: rd_data = 32'd0;
        endcase
    end

    assign bus.dout       = reset ? 32'd0 : rd_data;
    assign bus.req        = req;
    assign bus.epc_out    = epc_full;
    assign bus.handler_pc = HANDLER_PC;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= bus.hwint;
            if (req) begin
                exl      <= 1'b1;
                exc_code <= int_req ? 5'd0 : bus.m_exc;
                bd       <= bus.m_bd;
                epc      <= epc_sel[31:2];
            end else if (bus.eret) begin
                exl <= 1'b0;
            end else if (bus.we) begin
                unique case (1'b1)
                    bus.a2 == 5'd12: begin
                        im  <= bus.din[15:10];
                        exl <= bus.din[1];
                        ie  <= bus.din[0];
                    end
                    bus.a2 == 5'd14: epc <= bus.din[31:2];
                    default: ;
                endcase
            end
        end
    end

    assign unused_bits = ^{bus.din[9:2], epc_sel[1:0]};
endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: reset, syscall, delay-slot RI,
// interrupt priority/masking, eret/mtc0 collisions, async reset.
module tb_cp0_exc_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    cp0_exc_unit_if bus ();

    cp0_exc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.a1    = 5'd0;
        bus.a2    = 5'd0;
        bus.din   = 32'd0;
        bus.we    = 1'b0;
        bus.m_pc  = 32'd0;
        bus.m_exc = 5'd0;
        bus.m_bd  = 1'b0;
        bus.hwint = 6'd0;
        bus.eret  = 1'b0;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        bus.a1 = 5'd15;
        #2;
        n_checks++;
        if (bus.req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_req: got %0b want 0", bus.req);
        end
        n_checks++;
        if (bus.dout !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_dout: got %h want 0", bus.dout);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.a1 = 5'd12;
        #1;
        n_checks++;
        if (bus.dout !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_sr: got %h want 0", bus.dout);
        end
        bus.a1 = 5'd13;
        #1;
        n_checks++;
        if (bus.dout !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_cause: got %h want 0", bus.dout);
        end
        bus.a1 = 5'd14;
        #1;
        n_checks++;
        if (bus.dout !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_epc: got %h want 0", bus.dout);
        end
        bus.a1 = 5'd15;
        #1;
        n_checks++;
        if (bus.dout !== 32'h2004_0707) begin
            n_fail++;
            $display("FAIL rst_prid: got %h want 20040707", bus.dout);
        end
        bus.a1 = 5'd7;
        #1;
        n_checks++;
        if (bus.dout !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_a1_7: got %h want 0", bus.dout);
        end
        n_checks++;
        if (bus.handler_pc !== 32'h0000_4180) begin
            n_fail++;
            $display("FAIL handler_pc: got %h want 4180", bus.handler_pc);
        end
    endtask

    task automatic test_syscall();
        @(negedge clk);
        bus.m_exc = 5'd8;
        bus.m_pc  = 32'h3010;
        bus.m_bd  = 1'b0;
        #1;
        n_checks++;
        if (bus.req !== 1'b1) begin
            n_fail++;
            $display("FAIL sys_req: got %0b want 1", bus.req);
        end
        after_edge();
        n_checks++;
        if (bus.req !== 1'b0) begin
            n_fail++;
            $display("FAIL sys_no_nest: got %0b want 0", bus.req);
        end
        bus.a1 = 5'd13;
        #1;
        n_checks++;
        if (bus.dout !== 32'h0000_0020) begin
            n_fail++;
            $display("FAIL sys_cause: got %h want 00000020", bus.dout);
        end
        bus.a1 = 5'd14;
        #1;
        n_checks++;
        if (bus.dout !== 32'h3010) begin
            n_fail++;
            $display("FAIL sys_epc: got %h want 3010", bus.dout);
        end
        n_checks++;
        if (bus.epc_out !== 32'h3010) begin
            n_fail++;
            $display("FAIL sys_epc_out: got %h want 3010", bus.epc_out);
        end
        bus.a1 = 5'd12;
        #1;
        n_checks++;
        if (bus.dout !== 32'h2) begin
            n_fail++;
            $display("FAIL sys_exl: got %h want 2", bus.dout);
        end
        @(negedge clk);
        bus.m_exc = 5'd0;
        bus.eret  = 1'b1;
        after_edge();
        bus.eret = 1'b0;
        n_checks++;
        if (bus.dout !== 32'd0) begin
            n_fail++;
            $display("FAIL sys_eret: got %h want 0", bus.dout);
        end
    endtask

    task automatic test_ri_delay_slot();
        @(negedge clk);
        bus.m_exc = 5'd10;
        bus.m_pc  = 32'h3024;
        bus.m_bd  = 1'b1;
        #1;
        n_checks++;
        if (bus.req !== 1'b1) begin
            n_fail++;
            $display("FAIL ri_req: got %0b want 1", bus.req);
        end
        after_edge();
        bus.m_exc = 5'd0;
        bus.m_bd  = 1'b0;
        bus.a1    = 5'd13;
        #1;
        n_checks++;
        if (bus.dout !== 32'h8000_0028) begin
            n_fail++;
            $display("FAIL ri_cause: got %h want 80000028", bus.dout);
        end
        n_checks++;
        if (bus.epc_out !== 32'h3020) begin
            n_fail++;
            $display("FAIL ri_epc: got %h want 3020", bus.epc_out);
        end
        @(negedge clk);
        bus.eret = 1'b1;
        after_edge();
        bus.eret = 1'b0;
    endtask

    task automatic test_interrupt();
        @(negedge clk);
        bus.we  = 1'b1;
        bus.a2  = 5'd12;
        bus.din = 32'h0000_0401;
        after_edge();
        bus.we = 1'b0;
        bus.a1 = 5'd12;
        #1;
        n_checks++;
        if (bus.dout !== 32'h0000_0401) begin
            n_fail++;
            $display("FAIL int_sr: got %h want 00000401", bus.dout);
        end
        @(negedge clk);
        bus.hwint = 6'b000001;
        bus.m_exc = 5'd10;
        bus.m_pc  = 32'h3040;
        #1;
        n_checks++;
        if (bus.req !== 1'b1) begin
            n_fail++;
            $display("FAIL int_req: got %0b want 1", bus.req);
        end
        after_edge();
        bus.m_exc = 5'd0;
        bus.a1    = 5'd13;
        #1;
        n_checks++;
        if (bus.dout !== 32'h0000_0400) begin
            n_fail++;
            $display("FAIL int_cause: got %h want 00000400", bus.dout);
        end
        n_checks++;
        if (bus.epc_out !== 32'h3040) begin
            n_fail++;
            $display("FAIL int_epc: got %h want 3040", bus.epc_out);
        end
        @(negedge clk);
        bus.hwint = 6'd0;
        bus.eret  = 1'b1;
        after_edge();
        bus.eret = 1'b0;
        @(negedge clk);
        bus.we  = 1'b1;
        bus.a2  = 5'd12;
        bus.din = 32'h0000_0801;
        after_edge();
        bus.we = 1'b0;
        @(negedge clk);
        bus.hwint = 6'b000001;
        #1;
        n_checks++;
        if (bus.req !== 1'b0) begin
            n_fail++;
            $display("FAIL int_masked: got %0b want 0", bus.req);
        end
        bus.hwint = 6'b000010;
        #1;
        n_checks++;
        if (bus.req !== 1'b1) begin
            n_fail++;
            $display("FAIL int_unmasked: got %0b want 1", bus.req);
        end
        bus.hwint = 6'd0;
    endtask

    task automatic test_eret_collision();
        @(negedge clk);
        bus.hwint = 6'b000010;
        bus.m_pc  = 32'h3050;
        after_edge();
        bus.m_exc = 5'd8;
        #1;
        n_checks++;
        if (bus.req !== 1'b0) begin
            n_fail++;
            $display("FAIL col_exl_block: got %0b want 0", bus.req);
        end
        @(negedge clk);
        bus.m_exc = 5'd0;
        bus.eret  = 1'b1;
        after_edge();
        bus.eret = 1'b0;
        n_checks++;
        if (bus.req !== 1'b1) begin
            n_fail++;
            $display("FAIL col_eret_req: got %0b want 1", bus.req);
        end
        bus.a1 = 5'd12;
        #1;
        n_checks++;
        if (bus.dout !== 32'h0000_0801) begin
            n_fail++;
            $display("FAIL col_eret_sr: got %h want 00000801", bus.dout);
        end
        @(negedge clk);
        bus.m_pc = 32'h3060;
        bus.we   = 1'b1;
        bus.a2   = 5'd14;
        bus.din  = 32'h3007;
        after_edge();
        bus.we = 1'b0;
        n_checks++;
        if (bus.epc_out !== 32'h3060) begin
            n_fail++;
            $display("FAIL col_req_mtc0: got %h want 3060", bus.epc_out);
        end
        @(negedge clk);
        bus.hwint = 6'd0;
        bus.eret  = 1'b1;
        after_edge();
        bus.eret = 1'b0;
        @(negedge clk);
        bus.we  = 1'b1;
        bus.a2  = 5'd14;
        bus.din = 32'h3007;
        #1;
        n_checks++;
        if (bus.epc_out !== 32'h3060) begin
            n_fail++;
            $display("FAIL col_epc_early: got %h want 3060", bus.epc_out);
        end
        after_edge();
        bus.we = 1'b0;
        n_checks++;
        if (bus.epc_out !== 32'h3004) begin
            n_fail++;
            $display("FAIL col_mtc0_epc: got %h want 3004", bus.epc_out);
        end
        @(negedge clk);
        bus.we  = 1'b1;
        bus.a2  = 5'd13;
        bus.din = 32'hffff_ffff;
        after_edge();
        bus.we = 1'b0;
        bus.a1 = 5'd13;
        #1;
        n_checks++;
        if (bus.dout !== 32'd0) begin
            n_fail++;
            $display("FAIL col_cause_ro: got %h want 0", bus.dout);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.m_exc = 5'd8;
        bus.m_pc  = 32'h3010;
        bus.eret  = 1'b1;
        #1;
        n_checks++;
        if (bus.req !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_req: got %0b want 1", bus.req);
        end
        after_edge();
        bus.m_exc = 5'd0;
        bus.eret  = 1'b0;
        bus.a1    = 5'd12;
        #1;
        n_checks++;
        if (bus.dout !== 32'h0000_0803) begin
            n_fail++;
            $display("FAIL ar_eret_drop: got %h want 00000803", bus.dout);
        end
        n_checks++;
        if (bus.epc_out !== 32'h3010) begin
            n_fail++;
            $display("FAIL ar_epc_pre: got %h want 3010", bus.epc_out);
        end
        bus.hwint = 6'b000010;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.req !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_req_low: got %0b want 0", bus.req);
        end
        n_checks++;
        if (bus.epc_out !== 32'd0) begin
            n_fail++;
            $display("FAIL ar_epc_out: got %h want 0", bus.epc_out);
        end
        n_checks++;
        if (bus.dout !== 32'd0) begin
            n_fail++;
            $display("FAIL ar_dout: got %h want 0", bus.dout);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.dout !== 32'd0) begin
            n_fail++;
            $display("FAIL ar_sr: got %h want 0", bus.dout);
        end
        n_checks++;
        if (bus.req !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_req_post: got %0b want 0", bus.req);
        end
        bus.a1 = 5'd14;
        #1;
        n_checks++;
        if (bus.dout !== 32'd0) begin
            n_fail++;
            $display("FAIL ar_epc: got %h want 0", bus.dout);
        end
        bus.hwint = 6'd0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_syscall();
        test_ri_delay_slot();
        test_interrupt();
        test_eret_collision();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
